// File: rtl/rv32_pkg.sv
// rv32_pkg: shared core constants; port ids used by the response demux and its bench
package rv32_pkg;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/mem_resp_demux_if.sv
// mem_resp_demux_if: request tracking, memory response and port A/B response signals; slave = demux side, master = environment side
interface mem_resp_demux_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic                          req_fire_i;
    logic                          req_sel_i;
    logic                          req_ready_o;
    logic                          rsp_valid_i;
    logic                          rsp_ready_o;
    logic [DATA_WIDTH-1:0]         rsp_data_i;
    logic                          a_valid_o;
    logic [DATA_WIDTH-1:0]         a_data_o;
    logic                          a_ready_i;
    logic                          b_valid_o;
    logic [DATA_WIDTH-1:0]         b_data_o;
    logic                          b_ready_i;
    logic [$clog2(DEPTH+1)-1:0]    outstanding_o;
    logic                          err_o;

    modport slave (
        input  req_fire_i, req_sel_i, rsp_valid_i, rsp_data_i, a_ready_i, b_ready_i,
        output req_ready_o, rsp_ready_o, a_valid_o, a_data_o, b_valid_o, b_data_o, outstanding_o, err_o
    );
    modport master (
        output req_fire_i, req_sel_i, rsp_valid_i, rsp_data_i, a_ready_i, b_ready_i,
        input  req_ready_o, rsp_ready_o, a_valid_o, a_data_o, b_valid_o, b_data_o, outstanding_o, err_o
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; ports clk, rst_n (async active-low), push/pop, din/dout (head), full, empty, count
module sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             do_push, do_pop;
    // a push while full is dropped even if a pop frees a slot this same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            count <= (do_push && !do_pop) ? count + CW'(1) : (!do_push && do_pop) ? count - CW'(1) : count;
        end
    end
endmodule

// File: rtl/mem_resp_demux.sv
// mem_resp_demux: routes in-order memory responses to port A or B using a tracking FIFO of requester ids.
// Ports: clk, rst_n (async active-low), bus (mem_resp_demux_if.slave) with request tracking, response handshake, A/B channels, outstanding count, err.
// Option: MEM_RESP_DEMUX_ERR_EN accepts and drops responses arriving with nothing outstanding and sets sticky err_o.
module mem_resp_demux
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic clk,
    input logic rst_n,
    mem_resp_demux_if.slave bus
);
    logic full, empty, head, head_ready, stray_ok, a_sel, b_sel;
    sync_fifo #(.WIDTH(1), .DEPTH(DEPTH)) u_trk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.req_fire_i),
        .pop   (bus.rsp_valid_i && bus.rsp_ready_o),
        .din   (bus.req_sel_i),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (bus.outstanding_o)
    );
`ifdef MEM_RESP_DEMUX_ERR_EN
    logic err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else if (bus.rsp_valid_i && empty) err <= 1'b1;
    end
    assign bus.err_o = err;
    // stray beats are swallowed, but never while reset holds the block
    assign stray_ok = rst_n;
`else
    assign bus.err_o = 1'b0;
    assign stray_ok  = 1'b0;
`endif
    // empty means no port is selected, so nothing is routed and no bypass exists
    assign a_sel           = !empty && head == PORT_A;
    assign b_sel           = !empty && head == PORT_B;
    assign head_ready      = head == PORT_B ? bus.b_ready_i : bus.a_ready_i;
    assign bus.req_ready_o = !full;
    assign bus.rsp_ready_o = empty ? stray_ok : head_ready;
    assign bus.a_valid_o   = bus.rsp_valid_i && a_sel;
    assign bus.b_valid_o   = bus.rsp_valid_i && b_sel;
    assign bus.a_data_o    = a_sel ? bus.rsp_data_i : '0;
    assign bus.b_data_o    = b_sel ? bus.rsp_data_i : '0;
endmodule

// File: doc/mem_resp_demux.md
MEM_RESP_DEMUX -- requirements
Module: mem_resp_demux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the response data width.
REQ-002 SHALL have parameter DEPTH, default 4, giving max outstanding requests (power of two, >=2).
REQ-003 SHALL have clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have req_fire_i, input, 1 bit: a request from the upstream 2:1 mux was accepted by memory this cycle.
REQ-006 SHALL have req_sel_i, input, 1 bit: requester of that request; 0 = port A, 1 = port B.
REQ-007 SHALL have req_ready_o, output, 1 bit: tracker can accept another request.
REQ-008 SHALL have rsp_valid_i / rsp_ready_o, input / output, 1 bit each: memory response handshake.
REQ-009 SHALL have rsp_data_i, input, DATA_WIDTH: response data.
REQ-010 SHALL have a_valid_o, a_data_o[DATA_WIDTH], a_ready_i: port A response channel; b_valid_o, b_data_o, b_ready_i: same for port B.
REQ-011 SHALL have outstanding_o, output, $clog2(DEPTH+1) bits: tracked request count.
REQ-012 SHALL have err_o, output, 1 bit: sticky stray-response flag.

Function
REQ-013 SHALL record req_sel_i in an in-order tracking FIFO on every cycle where req_fire_i && req_ready_o.
REQ-014 SHALL drive req_ready_o = !full; a push is blocked when full even if a pop occurs the same cycle.
REQ-015 SHALL route each response to the port named by the FIFO head, combinationally, zero cycles of latency.
REQ-016 SHALL drive the selected port: valid = rsp_valid_i && !empty, data = rsp_data_i; the unselected port: valid 0, data 0.
REQ-017 SHALL drive rsp_ready_o = !empty && ready of the head port (a_ready_i or b_ready_i).
REQ-018 SHALL pop the FIFO head on each cycle where rsp_valid_i && rsp_ready_o.
REQ-019 SHALL treat push and pop in the same cycle as count-neutral, with both pointers advancing.
REQ-020 SHALL wrap read and write pointers modulo DEPTH.
REQ-021 SHALL not bypass: with the FIFO empty, a same-cycle push does not make the response routable that cycle.
REQ-022 SHALL hold the routing decision while the selected port stalls; the head does not change until its handshake.
REQ-023 SHALL drive outstanding_o with the registered entry count, 0..DEPTH.

Reset
REQ-024 SHALL, on rst_n low, immediately clear pointers, count, and err_o, and drive req_ready_o=1, rsp_ready_o=0, a_valid_o=0, b_valid_o=0, both data outputs 0, and outstanding_o=0.
REQ-025 SHALL, when reset is asserted mid-operation, discard all tracked requests; responses still in flight are handled per REQ-027/028.

Configuration
REQ-026 SHALL gate stray-response handling with the macro MEM_RESP_DEMUX_ERR_EN.
REQ-027 With the macro defined: when empty, the block SHALL drive rsp_ready_o=1 and drop any rsp_valid_i beat, without asserting either port valid, and SHALL set err_o=1 until reset.
REQ-028 Without the macro: the block SHALL keep rsp_ready_o=0 when empty, so stray responses stall, and SHALL tie err_o to 0.

Structure
REQ-029 SHALL place the constants PORT_A=1'b0 and PORT_B=1'b1 in the shared core package rv32_pkg.
REQ-030 SHALL implement the tracker as one sub-module, sync_fifo (parameters WIDTH=1 and DEPTH), reusable elsewhere in the core.
REQ-031 SHALL keep the routing and handshake logic in mem_resp_demux.

Verification
REQ-032 Stimulus: push sel=0, then a response 32'h0000_000A with a_ready=1. Required: a_valid=1, a_data=32'hA, b_valid=0, b_data=0; outstanding goes 1 -> 0.
REQ-033 Stimulus: push sel 0,1,1,0; then responses 5,6,7,8 with both ports ready. Required: A receives 5 and 8, B receives 6 and 7, in order.
REQ-034 Stimulus: push 4 entries (DEPTH=4). Required: req_ready_o=0; a 5th push is ignored and outstanding stays 4; a same-cycle push plus pop while full still drops the push.
REQ-035 Stimulus: head sel=1 with b_ready=0 for 3 cycles and rsp_valid held at 32'h55. Required: rsp_ready=0 and b_valid=1 throughout, no pop; b_ready=1 then completes the transfer in 1 cycle.
REQ-036 Stimulus: rsp_valid with the FIFO empty. Required with MEM_RESP_DEMUX_ERR_EN: beat consumed, err_o=1 (sticky). Required without it: rsp_ready=0, err_o=0.
REQ-037 Stimulus: 3 entries outstanding, then rst_n pulsed low mid-cycle. Required: outstanding_o=0 and all valids 0 immediately, before the next edge.
